// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
// Module   : game_pkg
// Purpose  : Shared constants, types and helpers for the 2048 move logic.
//            Board encoding: cell i (i = row*4 + col, row 0 on top) lives at
//            bits [63-4i -: 4] of a 64-bit board word; values are exponents,
//            0 meaning an empty cell.
// Revision : 1.0 - initial release
// ============================================================================
package game_pkg;

  localparam int CELL_W    = 4;
  localparam int NUM_CELLS = 16;

  localparam logic [CELL_W-1:0] EMPTY = 4'd0;

  // One-hot move directions
  localparam logic [3:0] DIR_LEFT  = 4'b0001;
  localparam logic [3:0] DIR_RIGHT = 4'b0010;
  localparam logic [3:0] DIR_DOWN  = 4'b0100;
  localparam logic [3:0] DIR_UP    = 4'b1000;

  // Sequencer state encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LINE  = 2'd1;
  localparam logic [1:0] ST_SPAWN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef logic [CELL_W-1:0] cell_t;

  // LSB position of cell (row, col) inside a 64-bit board word.
  function automatic logic [5:0] cell_lsb(input logic [1:0] row, input logic [1:0] col);
    return 6'd60 - {row, col, 2'b00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/line_merge.sv
`default_nettype none
// ============================================================================
// Module   : line_merge
// Purpose  : Combinational 2048 merge of one 4-cell line. Element 0 is the
//            slide target. Non-empty cells are compacted toward element 0,
//            then equal neighbours merge once, scanning from element 0.
// Ports    : line_in  [3:0][3:0]  in   cells before the move
//            line_out [3:0][3:0]  out  cells after the move
//            merges   [1:0]       out  number of merges (0..2)
//            changed              out  line_out differs from line_in
// Revision : 1.0 - initial release
// ============================================================================
module line_merge
  import game_pkg::*;
(
  input  logic [3:0][CELL_W-1:0] line_in,
  output logic [3:0][CELL_W-1:0] line_out,
  output logic [1:0]             merges,
  output logic                   changed
);

  logic [3:0][CELL_W-1:0] comp;
  logic [2:0]             fill;

  // Merged value is exponent + 1, pinned at the top code.
  function automatic cell_t bump(input cell_t v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  // Compaction: pack non-empty cells toward element 0 in order.
  always_comb begin
    comp = '0;
    fill = '0;
    for (int j = 0; j < 4; j++) begin
      if (line_in[j] != EMPTY) begin
        comp[fill[1:0]] = line_in[j];
        fill            = fill + 3'd1;
      end
    end
  end

  // Merge: after compaction an equal pair at (2,3) implies elements 0 and 1
  // are occupied, so the few pair positions can be enumerated directly.
  always_comb begin
    line_out = comp;
    merges   = 2'd0;
    if (comp[0] != EMPTY && comp[0] == comp[1]) begin
      if (comp[2] != EMPTY && comp[2] == comp[3]) begin
        line_out = {EMPTY, EMPTY, bump(comp[2]), bump(comp[0])};
        merges   = 2'd2;
      end else begin
        line_out = {EMPTY, comp[3], comp[2], bump(comp[0])};
        merges   = 2'd1;
      end
    end else if (comp[1] != EMPTY && comp[1] == comp[2]) begin
      line_out = {EMPTY, comp[3], bump(comp[1]), comp[0]};
      merges   = 2'd1;
    end else if (comp[2] != EMPTY && comp[2] == comp[3]) begin
      line_out = {EMPTY, bump(comp[2]), comp[1], comp[0]};
      merges   = 2'd1;
    end
  end

  assign changed = (line_out != line_in);

endmodule
`default_nettype wire

// File: rtl/move_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : move_sequencer
// Purpose  : Sequences one 2048 move: four passes through a shared line_merge
//            (one per line), then a random tile spawn if the board changed,
//            then a one-cycle done pulse with the result and game status.
// Ports    : clock, reset_n          clock / synchronous active-low reset
//            start, direction[3:0]   move request (one-hot direction)
//            board_in[63:0]          board captured when start is accepted
//            busy                    move in progress
//            done                    result valid pulse
//            board_out[63:0]         resulting board (held until next done)
//            moved, merge_count[3:0] move summary
//            won, stuck              game status of board_out
// Revision : 1.0 - initial release
// ============================================================================
module move_sequencer
  import game_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter logic [3:0]  WIN_EXP   = 4'd11
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic [3:0]  direction,
  input  logic [63:0] board_in,
  output logic        busy,
  output logic        done,
  output logic [63:0] board_out,
  output logic        moved,
  output logic [3:0]  merge_count,
  output logic        won,
  output logic        stuck
);

  logic [1:0]  state_q, state_d;
  logic [63:0] work_q, work_d;
  logic [3:0]  dir_q, dir_d;
  logic [1:0]  line_q, line_d;
  logic        moved_acc_q, moved_acc_d;
  logic [3:0]  merge_acc_q, merge_acc_d;
  logic [3:0]  scan_q, scan_d;
  logic [3:0]  tile_q, tile_d;
  logic [3:0]  tries_q, tries_d;
  logic [15:0] lfsr_q, lfsr_d;

  logic [63:0] board_out_q, board_out_d;
  logic        moved_q, moved_d;
  logic [3:0]  merge_count_q, merge_count_d;
  logic        won_q, won_d;
  logic        stuck_q, stuck_d;

  logic [3:0][CELL_W-1:0] lm_in, lm_out;
  logic [1:0]             lm_merges;
  logic                   lm_changed;

  logic [3:0] elem_idx [4];
  logic       dir_valid;
  logic [5:0] scan_lsb;
  logic       board_won, board_empty, board_pair;

  assign dir_valid = (direction == DIR_LEFT)  || (direction == DIR_RIGHT) ||
                     (direction == DIR_DOWN)  || (direction == DIR_UP);
  assign scan_lsb  = cell_lsb(scan_q[3:2], scan_q[1:0]);

  // Cell index {row, col} of element j of the current line; element 0 is
  // the cell the line slides toward.
  always_comb begin
    for (int j = 0; j < 4; j++) begin
      case (dir_q)
        DIR_LEFT:  elem_idx[j] = {line_q, 2'(j)};
        DIR_RIGHT: elem_idx[j] = {line_q, 2'(3 - j)};
        DIR_UP:    elem_idx[j] = {2'(j), line_q};
        default:   elem_idx[j] = {2'(3 - j), line_q};
      endcase
    end
  end

  always_comb begin
    for (int j = 0; j < 4; j++) begin
      lm_in[j] = work_q[cell_lsb(elem_idx[j][3:2], elem_idx[j][1:0]) +: CELL_W];
    end
  end

  line_merge u_line_merge (
    .line_in  (lm_in),
    .line_out (lm_out),
    .merges   (lm_merges),
    .changed  (lm_changed)
  );

  // Sequencer next-state logic
  always_comb begin
    state_d     = state_q;
    work_d      = work_q;
    dir_d       = dir_q;
    line_d      = line_q;
    moved_acc_d = moved_acc_q;
    merge_acc_d = merge_acc_q;
    scan_d      = scan_q;
    tile_d      = tile_q;
    tries_d     = tries_q;
    lfsr_d      = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    case (state_q)
      ST_IDLE: begin
        if (start && dir_valid) begin
          work_d      = board_in;
          dir_d       = direction;
          line_d      = 2'd0;
          moved_acc_d = 1'b0;
          merge_acc_d = 4'd0;
          state_d     = ST_LINE;
        end
      end

      ST_LINE: begin
        for (int j = 0; j < 4; j++) begin
          work_d[cell_lsb(elem_idx[j][3:2], elem_idx[j][1:0]) +: CELL_W] = lm_out[j];
        end
        moved_acc_d = moved_acc_q | lm_changed;
        merge_acc_d = merge_acc_q + {2'b00, lm_merges};
        line_d      = line_q + 2'd1;
        if (line_q == 2'd3) begin
          if (moved_acc_d) begin
            // Spawn start position and tile value are fixed on entry.
            scan_d  = lfsr_q[3:0];
            tile_d  = (lfsr_q[7:4] == 4'd0) ? 4'd2 : 4'd1;
            tries_d = 4'd0;
            state_d = ST_SPAWN;
          end else begin
            state_d = ST_DONE;
          end
        end
      end

      ST_SPAWN: begin
        if (work_q[scan_lsb +: CELL_W] == EMPTY) begin
          work_d[scan_lsb +: CELL_W] = tile_q;
          state_d                    = ST_DONE;
        end else begin
          scan_d  = scan_q + 4'd1;
          tries_d = tries_q + 4'd1;
          // Sixteenth occupied cell: give up without writing.
          if (tries_q == 4'd15) begin
            state_d = ST_DONE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Status of the board that will be published
  always_comb begin
    board_won   = 1'b0;
    board_empty = 1'b0;
    board_pair  = 1'b0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (work_d[cell_lsb(2'(r), 2'(c)) +: CELL_W] == WIN_EXP) begin
          board_won = 1'b1;
        end
        if (work_d[cell_lsb(2'(r), 2'(c)) +: CELL_W] == EMPTY) begin
          board_empty = 1'b1;
        end
        if (c < 3 && work_d[cell_lsb(2'(r), 2'(c)) +: CELL_W] ==
                     work_d[cell_lsb(2'(r), 2'(c + 1)) +: CELL_W]) begin
          board_pair = 1'b1;
        end
        if (r < 3 && work_d[cell_lsb(2'(r), 2'(c)) +: CELL_W] ==
                     work_d[cell_lsb(2'(r + 1), 2'(c)) +: CELL_W]) begin
          board_pair = 1'b1;
        end
      end
    end
  end

  // Results are captured on the edge that enters DONE so they are already
  // valid while done is high.
  always_comb begin
    board_out_d   = board_out_q;
    moved_d       = moved_q;
    merge_count_d = merge_count_q;
    won_d         = won_q;
    stuck_d       = stuck_q;
    if (state_d == ST_DONE) begin
      board_out_d   = work_d;
      moved_d       = moved_acc_d;
      merge_count_d = merge_acc_d;
      won_d         = board_won;
      stuck_d       = !board_empty && !board_pair;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      work_q        <= '0;
      dir_q         <= DIR_LEFT;
      line_q        <= 2'd0;
      moved_acc_q   <= 1'b0;
      merge_acc_q   <= 4'd0;
      scan_q        <= 4'd0;
      tile_q        <= 4'd0;
      tries_q       <= 4'd0;
      lfsr_q        <= LFSR_SEED;
      board_out_q   <= '0;
      moved_q       <= 1'b0;
      merge_count_q <= 4'd0;
      won_q         <= 1'b0;
      stuck_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      work_q        <= work_d;
      dir_q         <= dir_d;
      line_q        <= line_d;
      moved_acc_q   <= moved_acc_d;
      merge_acc_q   <= merge_acc_d;
      scan_q        <= scan_d;
      tile_q        <= tile_d;
      tries_q       <= tries_d;
      lfsr_q        <= lfsr_d;
      board_out_q   <= board_out_d;
      moved_q       <= moved_d;
      merge_count_q <= merge_count_d;
      won_q         <= won_d;
      stuck_q       <= stuck_d;
    end
  end

  assign busy        = (state_q == ST_LINE) || (state_q == ST_SPAWN);
  assign done        = (state_q == ST_DONE);
  assign board_out   = board_out_q;
  assign moved       = moved_q;
  assign merge_count = merge_count_q;
  assign won         = won_q;
  assign stuck       = stuck_q;

endmodule
`default_nettype wire

// File: tb/tb_move_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_move_sequencer
// Purpose  : Self-checking bench for move_sequencer. Expected boards come
//            from a list/queue model of the 2048 rules plus a model of the
//            spawn LFSR running from reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_move_sequencer;

  localparam logic [15:0] SEED = 16'hACE1;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  direction = 4'd0;
  logic [63:0] board_in = 64'd0;
  logic        busy, done, moved, won, stuck;
  logic [63:0] board_out;
  logic [3:0]  merge_count;

  int n_total = 0;
  int n_pass  = 0;

  logic [15:0] m_lfsr;

  move_sequencer #(.LFSR_SEED(SEED), .WIN_EXP(4'd11)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .start       (start),
    .direction   (direction),
    .board_in    (board_in),
    .busy        (busy),
    .done        (done),
    .board_out   (board_out),
    .moved       (moved),
    .merge_count (merge_count),
    .won         (won),
    .stuck       (stuck)
  );

  always #5 clock = ~clock;

  // Free-running spawn LFSR as seen by the design: seeded on reset, one step per clock.
  always @(posedge clock) begin
    if (!reset_n) m_lfsr <= SEED;
    else          m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  // ---------------- reference model ----------------
  function automatic void coord(input logic [3:0] dir, input int k, input int j,
                                output int r, output int c);
    case (dir)
      4'b0001: begin r = k;     c = j;     end
      4'b0010: begin r = k;     c = 3 - j; end
      4'b1000: begin r = j;     c = k;     end
      default: begin r = 3 - j; c = k;     end
    endcase
  endfunction

  function automatic void model_move(input logic [63:0] b, input logic [3:0] dir,
                                     output logic [63:0] res, output int merges);
    int g[4][4];
    int q[$];
    int outl[4];
    int r, c, n;
    for (int i = 0; i < 16; i++) g[i / 4][i % 4] = int'(b[63 - 4 * i -: 4]);
    merges = 0;
    for (int k = 0; k < 4; k++) begin
      q.delete();
      for (int j = 0; j < 4; j++) begin
        coord(dir, k, j, r, c);
        if (g[r][c] != 0) q.push_back(g[r][c]);
      end
      for (int j = 0; j < 4; j++) outl[j] = 0;
      n = 0;
      while (q.size() > 0) begin
        if (q.size() >= 2 && q[0] == q[1]) begin
          outl[n] = (q[0] >= 15) ? 15 : q[0] + 1;
          merges++;
          void'(q.pop_front());
          void'(q.pop_front());
        end else begin
          outl[n] = q.pop_front();
        end
        n++;
      end
      for (int j = 0; j < 4; j++) begin
        coord(dir, k, j, r, c);
        g[r][c] = outl[j];
      end
    end
    res = 64'd0;
    for (int i = 0; i < 16; i++) res[63 - 4 * i -: 4] = 4'(g[i / 4][i % 4]);
  endfunction

  function automatic logic model_won(input logic [63:0] b);
    for (int i = 0; i < 16; i++) if (b[63 - 4 * i -: 4] == 4'd11) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic model_stuck(input logic [63:0] b);
    int g[4][4];
    for (int i = 0; i < 16; i++) g[i / 4][i % 4] = int'(b[63 - 4 * i -: 4]);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        if (g[r][c] == 0) return 1'b0;
        if (c < 3 && g[r][c] == g[r][c + 1]) return 1'b0;
        if (r < 3 && g[r][c] == g[r + 1][c]) return 1'b0;
      end
    return 1'b1;
  endfunction

  // ---------------- one move, fully checked against the model ----------------
  task automatic run_move(input string tag, input logic [63:0] b, input logic [3:0] dir,
                          output logic [63:0] got_b, output logic [3:0] got_mc,
                          output logic got_moved, output logic got_won, output logic got_stuck);
    logic [63:0] exp_b;
    int          exp_m;
    logic        exp_moved;
    int          exp_lat;
    int          idx;
    int          first_done;
    logic [3:0]  tile;
    bit          bad_timing;
    model_move(b, dir, exp_b, exp_m);
    exp_moved = (exp_b != b);
    exp_lat   = exp_moved ? 21 : 5;
    @(negedge clock);
    board_in = b; direction = dir; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    board_in = {$urandom, $urandom};
    direction = 4'($urandom);
    bad_timing = 1'b0;
    first_done = -1;
    for (int t = 1; t <= exp_lat; t++) begin
      if (t == 4 && exp_moved) begin
        idx  = int'(m_lfsr[3:0]);
        tile = (m_lfsr[7:4] == 4'd0) ? 4'd2 : 4'd1;
        for (int n = 0; n < 16; n++) begin
          if (exp_b[63 - 4 * idx -: 4] == 4'd0) begin
            exp_b[63 - 4 * idx -: 4] = tile;
            exp_lat = 5 + n + 1;
            break;
          end
          idx = (idx + 1) % 16;
        end
      end
      if (done === 1'b1 && first_done < 0) first_done = t;
      if (done !== (t == exp_lat) || busy !== (t < exp_lat)) bad_timing = 1'b1;
      if (t < exp_lat) @(negedge clock);
    end
    got_b = board_out; got_mc = merge_count; got_moved = moved;
    got_won = won; got_stuck = stuck;

    n_total++;
    if (bad_timing) $display("FAIL %s timing: first done at cycle %0d, required done only at cycle %0d with busy before it", tag, first_done, exp_lat);
    else n_pass++;
    n_total++;
    if (board_out !== exp_b) $display("FAIL %s board_out: got %h required %h", tag, board_out, exp_b);
    else n_pass++;
    n_total++;
    if (moved !== exp_moved) $display("FAIL %s moved: got %b required %b", tag, moved, exp_moved);
    else n_pass++;
    n_total++;
    if (merge_count !== 4'(exp_m)) $display("FAIL %s merge_count: got %0d required %0d", tag, merge_count, exp_m);
    else n_pass++;
    n_total++;
    if (won !== model_won(exp_b) || stuck !== model_stuck(exp_b))
      $display("FAIL %s status: got won=%b stuck=%b required won=%b stuck=%b", tag, won, stuck, model_won(exp_b), model_stuck(exp_b));
    else n_pass++;
    @(negedge clock);
    n_total++;
    if (done !== 1'b0 || board_out !== exp_b)
      $display("FAIL %s hold: got done=%b board_out=%h required done=0 board_out=%h", tag, done, board_out, exp_b);
    else n_pass++;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    n_total++;
    if ({busy, done, moved, won, stuck, merge_count, board_out} !== 72'd0)
      $display("FAIL reset_outputs: got busy=%b done=%b moved=%b won=%b stuck=%b mc=%0d board=%h required all 0",
               busy, done, moved, won, stuck, merge_count, board_out);
    else n_pass++;
    reset_n = 1'b1;
    @(negedge clock);
    n_total++;
    if (busy !== 1'b0 || done !== 1'b0)
      $display("FAIL reset_idle: got busy=%b done=%b required 0 0", busy, done);
    else n_pass++;
  endtask

  task automatic test_slide_merge();
    logic [63:0] b; logic [3:0] mc; logic mv, w, s;
    run_move("row_1122_left", 64'h1122_0000_0000_0000, 4'b0001, b, mc, mv, w, s);
    n_total++;
    if (b[63:56] !== 8'h23 || mc !== 4'd2 || mv !== 1'b1)
      $display("FAIL row_1122_fixed: got row0=%h mc=%0d moved=%b required 23 2 1", b[63:56], mc, mv);
    else n_pass++;
    run_move("row_2110_left", 64'h2110_0000_0000_0000, 4'b0001, b, mc, mv, w, s);
    n_total++;
    if (b[63:56] !== 8'h22 || mc !== 4'd1)
      $display("FAIL row_2110_fixed: got row0=%h mc=%0d required 22 1", b[63:56], mc);
    else n_pass++;
  endtask

  task automatic test_no_move();
    logic [63:0] b; logic [3:0] mc; logic mv, w, s;
    run_move("single_left", 64'h1000_0000_0000_0000, 4'b0001, b, mc, mv, w, s);
    n_total++;
    if (b !== 64'h1000_0000_0000_0000 || mv !== 1'b0 || mc !== 4'd0)
      $display("FAIL single_fixed: got board=%h moved=%b mc=%0d required 1000000000000000 0 0", b, mv, mc);
    else n_pass++;
  endtask

  task automatic test_column();
    logic [63:0] b; logic [3:0] mc; logic mv, w, s;
    run_move("col_down", 64'h1000_1000_1000_1000, 4'b0100, b, mc, mv, w, s);
    n_total++;
    if (b[31:28] !== 4'd2 || b[15:12] !== 4'd2 || mc !== 4'd2)
      $display("FAIL col_down_fixed: got r2c0=%0d r3c0=%0d mc=%0d required 2 2 2", b[31:28], b[15:12], mc);
    else n_pass++;
  endtask

  task automatic test_status();
    logic [63:0] b; logic [3:0] mc; logic mv, w, s;
    run_move("checker_up", 64'h1212_2121_1212_2121, 4'b1000, b, mc, mv, w, s);
    n_total++;
    if (mv !== 1'b0 || s !== 1'b1 || w !== 1'b0 || b !== 64'h1212_2121_1212_2121)
      $display("FAIL checker_fixed: got moved=%b stuck=%b won=%b board=%h required 0 1 0 unchanged", mv, s, w, b);
    else n_pass++;
    run_move("win_merge", 64'hAA00_0000_0000_0000, 4'b0001, b, mc, mv, w, s);
    n_total++;
    if (b[63:60] !== 4'hB || w !== 1'b1)
      $display("FAIL win_fixed: got c0=%0d won=%b required 11 1", b[63:60], w);
    else n_pass++;
    run_move("saturate", 64'hFF00_0000_0000_0000, 4'b0001, b, mc, mv, w, s);
    n_total++;
    if (b[63:60] !== 4'hF || mc !== 4'd1)
      $display("FAIL saturate_fixed: got c0=%0d mc=%0d required 15 1", b[63:60], mc);
    else n_pass++;
  endtask

  task automatic test_ignored();
    int dones;
    bit bad;
    @(negedge clock);
    board_in = 64'h1122_0000_0000_0000; direction = 4'b0011; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    bad = 1'b0;
    for (int t = 0; t < 10; t++) begin
      if (busy !== 1'b0 || done !== 1'b0) bad = 1'b1;
      @(negedge clock);
    end
    n_total++;
    if (bad) $display("FAIL bad_dir: got busy/done activity required none");
    else n_pass++;

    // start held high throughout the move
    board_in = 64'h1122_0000_0000_0000; direction = 4'b0001; start = 1'b1;
    dones = 0;
    bad = 1'b0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clock);
      if (done === 1'b1) begin
        dones++;
        start = 1'b0;
      end else if (dones > 0 && busy !== 1'b0) begin
        bad = 1'b1;
      end
    end
    start = 1'b0;
    n_total++;
    if (dones != 1 || bad)
      $display("FAIL start_while_busy: got %0d done pulses (busy after done=%b) required 1 (0)", dones, bad);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [63:0] b; logic [3:0] mc; logic mv, w, s;
    bit bad;
    @(negedge clock);
    board_in = 64'h1122_0000_0000_0000; direction = 4'b0001; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    n_total++;
    if ({busy, done, moved, won, stuck, merge_count, board_out} !== 72'd0)
      $display("FAIL mid_reset_outputs: got busy=%b done=%b moved=%b won=%b stuck=%b mc=%0d board=%h required all 0",
               busy, done, moved, won, stuck, merge_count, board_out);
    else n_pass++;
    reset_n = 1'b1;
    bad = 1'b0;
    for (int t = 0; t < 20; t++) begin
      if (done !== 1'b0 || busy !== 1'b0) bad = 1'b1;
      @(negedge clock);
    end
    n_total++;
    if (bad) $display("FAIL mid_reset_abort: got done/busy after reset required none");
    else n_pass++;
    run_move("after_reset", 64'h0101_2020_0303_4004, 4'b0010, b, mc, mv, w, s);
  endtask

  task automatic test_random();
    logic [63:0] b, rb; logic [3:0] mc; logic mv, w, s;
    logic [3:0] dir;
    for (int it = 0; it < 24; it++) begin
      b = 64'd0;
      for (int i = 0; i < 16; i++) begin
        if (it % 6 == 5 || $urandom_range(0, 1) == 1)
          b[63 - 4 * i -: 4] = 4'($urandom_range(1, 5));
      end
      dir = 4'b0001 << $urandom_range(0, 3);
      run_move("random", b, dir, rb, mc, mv, w, s);
    end
  endtask

  initial begin
    test_reset();
    test_slide_merge();
    test_no_move();
    test_column();
    test_status();
    test_ignored();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
